// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: USB receive line decoder. Samples DP/DM once per clock,
// checks SYNC, NRZI-decodes, strips stuffed bits, detects EOP and emits a
// registered bit stream with start/last framing strobes.
// Optional feature macro: RX_STUFF_ERR_EN (stuff violations become errors).
module usb_rx_decoder (
    input  logic clk,
    input  logic rst_L,
    input  logic dp_in,
    input  logic dm_in,
    input  logic rx_en,
    output logic bit_out,
    output logic bit_valid,
    output logic start,
    output logic last,
    output logic rx_active,
    output logic rx_err,
    output logic stuff_err
);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

    state_t     state, state_d;
    logic [2:0] sync_cnt, sync_cnt_d;   // SYNC bits received so far
    logic [2:0] ones_cnt, ones_cnt_d;   // consecutive decoded ones
    logic [1:0] se0_cnt, se0_cnt_d;     // SE0 samples seen in EOP
    logic       prev_j, prev_j_d;       // previous line level was J
    logic       first, first_d;         // next emitted bit is the first payload bit
    logic       seen_se0, seen_se0_d;   // ERROR has seen an SE0 (exit armed)
    logic       bit_out_d, bit_valid_d, start_d, last_d, rx_active_d;
    logic       rx_err_d, stuff_err_d;

    logic line_j, line_k, line_se0, line_se1, dec;

    assign line_j   =  dp_in & ~dm_in;
    assign line_k   = ~dp_in &  dm_in;
    assign line_se0 = ~dp_in & ~dm_in;
    assign line_se1 =  dp_in &  dm_in;
    // NRZI: a 1 is an unchanged level; only meaningful on J/K samples
    assign dec      = (line_j == prev_j);

    // State, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state     <= S_IDLE;
            sync_cnt  <= '0;
            ones_cnt  <= '0;
            se0_cnt   <= '0;
            prev_j    <= 1'b1;
            first     <= 1'b0;
            seen_se0  <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            start     <= 1'b0;
            last      <= 1'b0;
            rx_active <= 1'b0;
            rx_err    <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            state     <= state_d;
            sync_cnt  <= sync_cnt_d;
            ones_cnt  <= ones_cnt_d;
            se0_cnt   <= se0_cnt_d;
            prev_j    <= prev_j_d;
            first     <= first_d;
            seen_se0  <= seen_se0_d;
            bit_out   <= bit_out_d;
            bit_valid <= bit_valid_d;
            start     <= start_d;
            last      <= last_d;
            rx_active <= rx_active_d;
            rx_err    <= rx_err_d;
            stuff_err <= stuff_err_d;
        end
    end

    // Next-state, counter and output decode for the current line sample
    always_comb begin
        state_d     = state;
        sync_cnt_d  = sync_cnt;
        ones_cnt_d  = ones_cnt;
        se0_cnt_d   = se0_cnt;
        prev_j_d    = prev_j;
        first_d     = first;
        seen_se0_d  = seen_se0;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        start_d     = 1'b0;
        last_d      = 1'b0;
        rx_err_d    = 1'b0;
        stuff_err_d = 1'b0;

        if (!rx_en) begin
            // host owns the bus: abort silently, overriding any error
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    // first K is SYNC bit 0 (decoded 0 against idle J)
                    if (line_k) begin
                        state_d    = S_SYNC;
                        sync_cnt_d = 3'd1;
                        prev_j_d   = 1'b0;
                    end
                end
                S_SYNC: begin
                    if (line_j || line_k) begin
                        prev_j_d = line_j;
                        if (sync_cnt == 3'd7) begin
                            if (dec) begin
                                state_d    = S_DATA;
                                ones_cnt_d = 3'd1;   // trailing SYNC 1 counts toward stuffing
                                first_d    = 1'b1;
                                sync_cnt_d = '0;
                            end else begin
                                state_d = S_ERROR;
                            end
                        end else if (!dec) begin
                            sync_cnt_d = sync_cnt + 3'd1;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end else begin
                        state_d = S_ERROR;
                    end
                end
                S_DATA: begin
                    if (line_j || line_k) begin
                        prev_j_d = line_j;
                        if (ones_cnt == 3'd6) begin
                            ones_cnt_d = '0;
                            if (dec) begin
`ifdef RX_STUFF_ERR_EN
                                stuff_err_d = 1'b1;
                                state_d     = S_ERROR;
`endif
                            end
                        end else begin
                            bit_out_d   = dec;
                            bit_valid_d = 1'b1;
                            start_d     = first;
                            first_d     = 1'b0;
                            ones_cnt_d  = dec ? ones_cnt + 3'd1 : 3'd0;
                        end
                    end else if (line_se0) begin
                        state_d   = S_EOP;
                        se0_cnt_d = 2'd1;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
                S_EOP: begin
                    if (line_se0 && se0_cnt == 2'd1) begin
                        se0_cnt_d = 2'd2;
                    end else if (line_j && se0_cnt == 2'd2) begin
                        last_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
                S_ERROR: begin
                    if (line_se0) begin
                        seen_se0_d = 1'b1;
                    end else if (line_j && seen_se0) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // every entry into ERROR is reported once and clears the framing context
        if (state_d == S_ERROR && state != S_ERROR) begin
            rx_err_d   = 1'b1;
            seen_se0_d = 1'b0;
            ones_cnt_d = '0;
            se0_cnt_d  = '0;
            sync_cnt_d = '0;
            first_d    = 1'b0;
        end

        // IDLE always starts from a clean slate with the line assumed at J
        if (state_d == S_IDLE) begin
            sync_cnt_d = '0;
            ones_cnt_d = '0;
            se0_cnt_d  = '0;
            prev_j_d   = 1'b1;
            first_d    = 1'b0;
            seen_se0_d = 1'b0;
        end

        rx_active_d = (state_d == S_DATA) || (state_d == S_EOP);
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder: directed self-checking bench for usb_rx_decoder.
// Inputs change on the falling edge; outputs are read 1 ns after the rising
// edge, so each check sees the response to the symbol just driven.
module tb_usb_rx_decoder;

    localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00, LSE1 = 2'b11;

    logic clk = 1'b0;
    logic rst_L, dp_in, dm_in, rx_en;
    logic bit_out, bit_valid, start, last, rx_active, rx_err, stuff_err;
    logic [6:0] outs;
    logic lvl;   // current transmitted level, 1 = J
    int n_cmp = 0;
    int n_bad = 0;

    assign outs = {bit_out, bit_valid, start, last, rx_active, rx_err, stuff_err};

    always #5 clk = ~clk;

    usb_rx_decoder dut (
        .clk(clk), .rst_L(rst_L), .dp_in(dp_in), .dm_in(dm_in), .rx_en(rx_en),
        .bit_out(bit_out), .bit_valid(bit_valid), .start(start), .last(last),
        .rx_active(rx_active), .rx_err(rx_err), .stuff_err(stuff_err)
    );

    task automatic cyc(input logic [1:0] ln);
        @(negedge clk);
        dp_in = ln[1];
        dm_in = ln[0];
        @(posedge clk);
        #1;
    endtask

    // NRZI-encode one wire bit (stuffing already present in the caller's bits)
    task automatic wbit(input logic b);
        if (!b) lvl = ~lvl;
        cyc(lvl ? LJ : LK);
    endtask

    task automatic send_sync();
        cyc(LK); cyc(LJ); cyc(LK); cyc(LJ);
        cyc(LK); cyc(LJ); cyc(LK); cyc(LK);
        lvl = 1'b0;
    endtask

    task automatic test_reset();
        rst_L = 1'b0; rx_en = 1'b1; dp_in = 1'b1; dm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs, 7'b0); end
        rst_L = 1'b1;
        cyc(LJ); cyc(LJ);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL idle_outs: got %b want %b", outs, 7'b0); end
        lvl = 1'b1;
    endtask

    task automatic test_ack(input string tag);
        logic [7:0] pid;
        pid = 8'hD2;
        send_sync();
        n_cmp++;
        if ({rx_active, rx_err, start, bit_valid} !== 4'b1000) begin
            n_bad++; $display("FAIL %s sync_done: got %b want 1000", tag, {rx_active, rx_err, start, bit_valid});
        end
        for (int i = 0; i < 8; i++) begin
            wbit(pid[i]);
            n_cmp++;
            if ({bit_out, bit_valid, start, last, rx_err} !== {pid[i], 1'b1, (i == 0), 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL %s pid_bit%0d: got %b want %b", tag, i,
                         {bit_out, bit_valid, start, last, rx_err}, {pid[i], 1'b1, (i == 0), 1'b0, 1'b0});
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(LSE0);
            n_cmp++;
            if ({bit_valid, last, rx_active, rx_err} !== 4'b0010) begin
                n_bad++; $display("FAIL %s eop_se0_%0d: got %b want 0010", tag, i, {bit_valid, last, rx_active, rx_err});
            end
        end
        cyc(LJ);
        n_cmp++;
        if ({bit_valid, last, rx_active, rx_err} !== 4'b0100) begin
            n_bad++; $display("FAIL %s eop_last: got %b want 0100", tag, {bit_valid, last, rx_active, rx_err});
        end
        cyc(LJ);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL %s after_last: got %b want %b", tag, outs, 7'b0); end
        lvl = 1'b1;
    endtask

    task automatic test_stuffing();
        logic [9:0] wb, vm;
        int nvalid;
        wb = 10'b0_111_0_11111;   // five ones, stuffed 0, three ones, data 0
        vm = 10'b1_111_0_11111;
        nvalid = 0;
        send_sync();
        for (int i = 0; i < 10; i++) begin
            wbit(wb[i]);
            n_cmp++;
            if ({bit_out & bit_valid, bit_valid, rx_err, stuff_err} !== {wb[i] & vm[i], vm[i], 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL stuff_bit%0d: got %b want %b", i,
                         {bit_out & bit_valid, bit_valid, rx_err, stuff_err}, {wb[i] & vm[i], vm[i], 1'b0, 1'b0});
            end
            if (bit_valid && bit_out) nvalid++;
        end
        n_cmp++;
        if (nvalid !== 8) begin n_bad++; $display("FAIL stuff_ones: got %0d want 8", nvalid); end
        cyc(LSE0); cyc(LSE0); cyc(LJ);
        n_cmp++;
        if ({last, rx_err} !== 2'b10) begin n_bad++; $display("FAIL stuff_last: got %b want 10", {last, rx_err}); end
        cyc(LJ);
        lvl = 1'b1;
    endtask

    task automatic test_stuff_violation();
        send_sync();
        for (int i = 0; i < 5; i++) wbit(1'b1);
        n_cmp++;
        if ({bit_out, bit_valid} !== 2'b11) begin n_bad++; $display("FAIL viol_pre: got %b want 11", {bit_out, bit_valid}); end
        wbit(1'b1);
`ifdef RX_STUFF_ERR_EN
        n_cmp++;
        if ({stuff_err, rx_err, rx_active, bit_valid} !== 4'b1100) begin
            n_bad++; $display("FAIL viol_err: got %b want 1100", {stuff_err, rx_err, rx_active, bit_valid});
        end
        wbit(1'b1); cyc(LSE0); cyc(LSE0); cyc(LJ);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL viol_nolast: got %b want %b", outs, 7'b0); end
`else
        n_cmp++;
        if ({stuff_err, rx_err, rx_active, bit_valid} !== 4'b0010) begin
            n_bad++; $display("FAIL viol_drop: got %b want 0010", {stuff_err, rx_err, rx_active, bit_valid});
        end
        wbit(1'b1);
        n_cmp++;
        if ({bit_out, bit_valid, rx_err} !== 3'b110) begin
            n_bad++; $display("FAIL viol_cont: got %b want 110", {bit_out, bit_valid, rx_err});
        end
        cyc(LSE0); cyc(LSE0); cyc(LJ);
        n_cmp++;
        if ({last, rx_err} !== 2'b10) begin n_bad++; $display("FAIL viol_last: got %b want 10", {last, rx_err}); end
`endif
        cyc(LJ);
        lvl = 1'b1;
    endtask

    task automatic test_bad_sync();
        logic [1:0] seq [8];
        seq = '{LK, LJ, LK, LJ, LK, LK, LJ, LK};
        for (int i = 0; i < 8; i++) begin
            cyc(seq[i]);
            n_cmp++;
            if ({rx_err, start, bit_valid, rx_active} !== {(i == 5), 3'b000}) begin
                n_bad++;
                $display("FAIL badsync_%0d: got %b want %b", i, {rx_err, start, bit_valid, rx_active}, {(i == 5), 3'b000});
            end
        end
        cyc(LSE0); cyc(LJ);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL badsync_idle: got %b want %b", outs, 7'b0); end
        lvl = 1'b1;
        test_ack("after_badsync");
    endtask

    task automatic test_abort();
        send_sync();
        for (int i = 0; i < 20; i++) begin
            wbit(1'(i % 2));
            n_cmp++;
            if ({bit_out, bit_valid} !== {1'(i % 2), 1'b1}) begin
                n_bad++; $display("FAIL abort_bit%0d: got %b want %b", i, {bit_out, bit_valid}, {1'(i % 2), 1'b1});
            end
        end
        rx_en = 1'b0;
        cyc(LSE1);   // abort coincides with an error condition
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL abort_outs: got %b want %b", outs, 7'b0); end
        rx_en = 1'b1;
        cyc(LJ);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL abort_idle: got %b want %b", outs, 7'b0); end
        lvl = 1'b1;
        test_ack("after_abort");
    endtask

    task automatic test_reset_mid();
        send_sync();
        for (int i = 0; i < 30; i++) wbit(1'(i % 2));
        rst_L = 1'b0;
        wbit(1'b0);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL rstmid_outs: got %b want %b", outs, 7'b0); end
        rst_L = 1'b1;
        cyc(LJ);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL rstmid_idle: got %b want %b", outs, 7'b0); end
        lvl = 1'b1;
        test_ack("after_reset");
    endtask

    task automatic test_se1_data();
        send_sync();
        wbit(1'b0); wbit(1'b1);
        cyc(LSE1);
        n_cmp++;
        if ({rx_err, rx_active, last, bit_valid} !== 4'b1000) begin
            n_bad++; $display("FAIL se1_err: got %b want 1000", {rx_err, rx_active, last, bit_valid});
        end
        cyc(LSE0);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL se1_hold: got %b want %b", outs, 7'b0); end
        cyc(LJ); cyc(LJ);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL se1_idle: got %b want %b", outs, 7'b0); end
        lvl = 1'b1;
    endtask

    task automatic test_single_se0();
        send_sync();
        wbit(1'b1); wbit(1'b0);
        cyc(LSE0);
        n_cmp++;
        if ({rx_err, rx_active, last} !== 3'b010) begin
            n_bad++; $display("FAIL se0_one: got %b want 010", {rx_err, rx_active, last});
        end
        cyc(LJ);
        n_cmp++;
        if ({rx_err, rx_active, last} !== 3'b100) begin
            n_bad++; $display("FAIL se0_badeop: got %b want 100", {rx_err, rx_active, last});
        end
        cyc(LSE0); cyc(LJ);
        n_cmp++;
        if (outs !== 7'b0) begin n_bad++; $display("FAIL se0_idle: got %b want %b", outs, 7'b0); end
        lvl = 1'b1;
        test_ack("after_badeop");
    endtask

    task automatic test_zero_len();
        send_sync();
        cyc(LSE0);
        n_cmp++;
        if ({start, bit_valid, last, rx_active} !== 4'b0001) begin
            n_bad++; $display("FAIL zlen_se0: got %b want 0001", {start, bit_valid, last, rx_active});
        end
        cyc(LSE0); cyc(LJ);
        n_cmp++;
        if ({last, start, rx_active, rx_err} !== 4'b1000) begin
            n_bad++; $display("FAIL zlen_last: got %b want 1000", {last, start, rx_active, rx_err});
        end
        cyc(LJ);
        lvl = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ack("ack");
        test_stuffing();
        test_stuff_violation();
        test_bad_sync();
        test_abort();
        test_reset_mid();
        test_se1_data();
        test_single_se0();
        test_zero_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
